// File: rtl/skinny_ctrl_pkg.sv
// Shared definitions for the CMS1 Skinny-128-384 sequencer: register-file
// address map, operand widths and the controller state encoding.
package skinny_ctrl_pkg;

  localparam int WORD_W   = 32;
  localparam int STATE_W  = 256;   // shared plaintext / TK3 / ciphertext
  localparam int TWEAK_W  = 128;   // TK1, TK2
  localparam int RANDOM_W = 1216;  // masking seed

  // Word base addresses; word n of a field lands in bits [32n+31:32n].
  localparam int ADDR_INPUT  = 0;
  localparam int ADDR_KEY    = 8;
  localparam int ADDR_TWEAK1 = 16;
  localparam int ADDR_TWEAK2 = 20;
  localparam int ADDR_RANDOM = 24;
  localparam int ADDR_LIMIT  = 62;  // first unmapped word

  localparam int REG_BITS = ADDR_LIMIT * WORD_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ARM,
    ST_WAIT,
    ST_READ
  } state_t;

  // True for addresses that map onto a register-file word.
  function automatic logic addr_valid(input logic [5:0] addr);
    return addr < 6'(ADDR_LIMIT);
  endfunction

endpackage

// File: rtl/skinny_ctrl_regfile.sv
// Operand register file: 62 x 32-bit words written by the host, exposed as
// the core's operand buses. Writes land only while the sequencer is idle.
module skinny_ctrl_regfile
  import skinny_ctrl_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                idle_i,
  input  logic                wr_en_i,
  input  logic [5:0]          wr_addr_i,
  input  logic [WORD_W-1:0]   wr_data_i,
  output logic [STATE_W-1:0]  input_o,
  output logic [STATE_W-1:0]  key_o,
  output logic [TWEAK_W-1:0]  tweak1_o,
  output logic [TWEAK_W-1:0]  tweak2_o,
  output logic [RANDOM_W-1:0] random_o
);

  logic [ADDR_LIMIT-1:0][WORD_W-1:0] regs;
  logic [REG_BITS-1:0]               flat;
  logic                              wr_ok;

  assign wr_ok = wr_en_i && idle_i && addr_valid(wr_addr_i);

  // Word write; out-of-range or non-idle writes leave the file untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs <= '0;
    end else if (wr_ok) begin
      regs[wr_addr_i] <= wr_data_i;
    end
  end

  assign flat     = regs;
  assign input_o  = flat[ADDR_INPUT*WORD_W  +: STATE_W];
  assign key_o    = flat[ADDR_KEY*WORD_W    +: STATE_W];
  assign tweak1_o = flat[ADDR_TWEAK1*WORD_W +: TWEAK_W];
  assign tweak2_o = flat[ADDR_TWEAK2*WORD_W +: TWEAK_W];
  assign random_o = flat[ADDR_RANDOM*WORD_W +: RANDOM_W];

endmodule

// File: rtl/skinny_cms1_ctrl.sv
// Sequencer for the 2-share CMS1 Skinny-128-384 core: host loads operands,
// go starts the core, the ciphertext streams back as 32-bit words.
// Optional: define SKINNY_CTRL_TRIGGER_EN to add a scope trigger output
// that is high while the core is computing (ARM and WAIT).
module skinny_cms1_ctrl
  import skinny_ctrl_pkg::*;
#(
  parameter int NWORDS_OUT = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_en_i,
  input  logic [5:0]          wr_addr_i,
  input  logic [31:0]         wr_data_i,
  input  logic                go_i,
  output logic                busy_o,
  output logic                wr_err_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [31:0]         out_data_o,
  output logic                out_last_o,
  output logic                core_rst_no,
  output logic                core_start_o,
  input  logic                core_done_i,
  output logic [255:0]        core_input_o,
  output logic [255:0]        core_key_o,
  output logic [127:0]        core_tweak1_o,
  output logic [127:0]        core_tweak2_o,
  output logic [1215:0]       core_random_o,
  input  logic [255:0]        core_cipher_i
`ifdef SKINNY_CTRL_TRIGGER_EN
  ,
  output logic                trigger_o
`endif
);

  localparam logic [2:0] LAST_IDX = 3'(NWORDS_OUT - 1);

  state_t                            state_q, state_d;
  logic [2:0]                        cnt_q;
  logic [NWORDS_OUT-1:0][WORD_W-1:0] obuf_q;
  logic                              idle, hs, at_last, capture;

  assign idle    = (state_q == ST_IDLE);
  assign hs      = out_valid_o && out_ready_i;
  assign at_last = (cnt_q == LAST_IDX);
  // The core still reports done while being started, so done only counts
  // once the ARM cycle has passed.
  assign capture = (state_q == ST_WAIT) && core_done_i;

  skinny_ctrl_regfile u_regfile (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .idle_i    (idle),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .input_o   (core_input_o),
    .key_o     (core_key_o),
    .tweak1_o  (core_tweak1_o),
    .tweak2_o  (core_tweak2_o),
    .random_o  (core_random_o)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d      = state_q;
    busy_o       = 1'b1;
    core_start_o = 1'b0;
    out_valid_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (go_i) state_d = ST_START;
      end
      ST_START: begin
        core_start_o = 1'b1;
        state_d      = ST_ARM;
      end
      ST_ARM:  state_d = ST_WAIT;
      ST_WAIT: if (core_done_i) state_d = ST_READ;
      ST_READ: begin
        out_valid_o = 1'b1;
        if (out_ready_i && at_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_data_o = out_valid_o ? obuf_q[cnt_q] : '0;
  assign out_last_o = out_valid_o && at_last;

  // Ciphertext capture on the first done seen in WAIT.
  always_ff @(posedge clk_i) begin
    if (rst_i)        obuf_q <= '0;
    else if (capture) obuf_q <= core_cipher_i[NWORDS_OUT*WORD_W-1:0];
  end

  // Readout word index; holds on the last word instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i)                 cnt_q <= '0;
    else if (capture)          cnt_q <= '0;
    else if (hs && !at_last)   cnt_q <= cnt_q + 3'd1;
  end

  // Sticky write error; a dropped or unmapped write outranks a clearing go.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      wr_err_o <= 1'b0;
    else if (wr_en_i && (!idle || !addr_valid(wr_addr_i)))
      wr_err_o <= 1'b1;
    else if (idle && go_i)
      wr_err_o <= 1'b0;
  end

  // Core reset follows the system reset one cycle late.
  always_ff @(posedge clk_i) begin
    core_rst_no <= ~rst_i;
  end

`ifdef SKINNY_CTRL_TRIGGER_EN
  // Registered trigger, aligned with the ARM/WAIT state window.
  always_ff @(posedge clk_i) begin
    if (rst_i) trigger_o <= 1'b0;
    else       trigger_o <= (state_d == ST_ARM) || (state_d == ST_WAIT);
  end
`endif

endmodule

// File: tb/tb_skinny_cms1_ctrl.sv
// Self-checking bench for skinny_cms1_ctrl with a behavioural core model.
module tb_skinny_cms1_ctrl;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          wr_en_i = 1'b0;
  logic [5:0]    wr_addr_i = '0;
  logic [31:0]   wr_data_i = '0;
  logic          go_i = 1'b0;
  logic          busy_o, wr_err_o, out_valid_o, out_last_o;
  logic          out_ready_i = 1'b0;
  logic [31:0]   out_data_o;
  logic          core_rst_no, core_start_o;
  logic          core_done_i = 1'b0;
  logic [255:0]  core_input_o, core_key_o, core_cipher_i, cf;
  logic [127:0]  core_tweak1_o, core_tweak2_o;
  logic [1215:0] core_random_o;
`ifdef SKINNY_CTRL_TRIGGER_EN
  logic          trigger_o;
`endif

  always #5 clk_i = ~clk_i;

  skinny_cms1_ctrl #(.NWORDS_OUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .go_i(go_i), .busy_o(busy_o), .wr_err_o(wr_err_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_last_o(out_last_o), .core_rst_no(core_rst_no), .core_start_o(core_start_o),
    .core_done_i(core_done_i), .core_input_o(core_input_o), .core_key_o(core_key_o),
    .core_tweak1_o(core_tweak1_o), .core_tweak2_o(core_tweak2_o),
    .core_random_o(core_random_o), .core_cipher_i(core_cipher_i)
`ifdef SKINNY_CTRL_TRIGGER_EN
    , .trigger_o(trigger_o)
`endif
  );

  // Core model: cipher is an XOR mix of its operands; the bus carries the
  // inverted value except while done is asserted, so a mistimed capture shows.
  assign cf = core_input_o ^ core_key_o ^ {core_tweak2_o, core_tweak1_o} ^ core_random_o[255:0];
  assign core_cipher_i = core_done_i ? cf : ~cf;

  int          checks = 0, errors = 0;
  logic [31:0] mem [0:61];
  bit          m_err = 0, cmp_en = 0;
  logic [31:0] exp_q [$];
  int          op_hs = 0, cyc = 0, starts = 0, trig_cnt = 0;
  bit          p_stall = 0, p_rst = 1, p_last = 0;
  logic [31:0] p_data = '0;
  logic [1983:0] mf;
  logic [31:0] ew;

  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  function automatic logic [31:0] dat(input int a);
    return (a < 32) ? (32'd1 << a) : (32'hFFFF_0000 | 32'(a));
  endfunction

  // Expected ciphertext word w: plaintext ^ TK3 ^ tweak ^ seed words, all at
  // the same word offset inside their fields.
  function automatic logic [31:0] m_cword(input int w);
    return mem[w] ^ mem[8+w] ^ mem[16+w] ^ mem[24+w];
  endfunction

  function automatic logic [1983:0] m_flat();
    logic [1983:0] f;
    for (int a = 0; a < 62; a++) f[a*32 +: 32] = mem[a];
    return f;
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk_i) begin
    if (cmp_en && !rst_i) begin
      mf = m_flat();
      chk("wr_err", wr_err_o, m_err);
      chk("core_input", core_input_o, mf[255:0]);
      chk("core_key", core_key_o, mf[511:256]);
      chk("core_tweak1", core_tweak1_o, mf[639:512]);
      chk("core_tweak2", core_tweak2_o, mf[767:640]);
      checks++;
      if (core_random_o !== mf[1983:768]) begin
        errors++;
        for (int w = 0; w < 38; w++)
          if (core_random_o[w*32 +: 32] !== mf[768 + w*32 +: 32]) begin
            $display("FAIL core_random word %0d got=%h exp=%h", w,
                     core_random_o[w*32 +: 32], mf[768 + w*32 +: 32]);
            break;
          end
      end
      if (core_start_o) starts++;
      if (out_valid_o) begin
        chk("valid_busy", busy_o, 1);
        if (out_ready_i) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_word got=%h exp=none", out_data_o);
          end else begin
            ew = exp_q.pop_front();
            chk("out_data", out_data_o, ew);
            chk("out_last", out_last_o, (op_hs == 7));
            op_hs++;
          end
        end
      end else begin
        chk("last_idle", out_last_o, 0);
      end
      if (p_stall && !p_rst) begin
        chk("stall_valid", out_valid_o, 1);
        chk("stall_data", out_data_o, p_data);
        chk("stall_last", out_last_o, p_last);
      end
`ifdef SKINNY_CTRL_TRIGGER_EN
      if (trigger_o) trig_cnt++;
      if (out_valid_o || !busy_o) chk("trig_low", trigger_o, 0);
`endif
    end
    p_stall = out_valid_o && !out_ready_i;
    p_data  = out_data_o;
    p_last  = out_last_o;
    p_rst   = rst_i;
  end

  task automatic model_reset();
    for (int a = 0; a < 62; a++) mem[a] = '0;
    m_err = 0;
    exp_q.delete();
    op_hs = 0;
  endtask

  task automatic do_reset(input int n, input string tag);
    rst_i = 1; go_i = 0; wr_en_i = 0; core_done_i = 0; out_ready_i = 0;
    for (int i = 0; i < n; i++) tick();
    model_reset();
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_valid"}, out_valid_o, 0);
    chk({tag, "_last"}, out_last_o, 0);
    chk({tag, "_data"}, out_data_o, 0);
    chk({tag, "_start"}, core_start_o, 0);
    chk({tag, "_err"}, wr_err_o, 0);
    chk({tag, "_core_rst"}, core_rst_no, 0);
    chk({tag, "_input"}, core_input_o, 0);
    rst_i = 0;
    tick();
    chk({tag, "_core_rst_rel"}, core_rst_no, 1);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    wr_en_i = 1; wr_addr_i = 6'(a); wr_data_i = d;
    tick();
    wr_en_i = 0;
    if (a < 62) mem[a] = d;
    else        m_err = 1;
  endtask

  // One encryption: dly = cycles from the START cycle to done; rmode 0 =
  // ready held high, 2 = random ready with a 5-cycle stall on word 3.
  task automatic run_op(input int dly, input bit hold, input int rmode,
                        input bit wait_wr, input int co_addr, input logic [31:0] co_data);
    int t_start, d, early, cycles, stall, s0;
    if (co_addr >= 0) begin
      wr_en_i = 1; wr_addr_i = 6'(co_addr); wr_data_i = co_data;
    end
    if (hold) core_done_i = 1;
    s0 = starts; op_hs = 0;
    go_i = 1;
    tick();
    go_i = 0; wr_en_i = 0;
    if (co_addr >= 0) mem[co_addr] = co_data;
    m_err = 0;
    for (int w = 0; w < 8; w++) exp_q.push_back(m_cword(w));
    t_start = cyc; trig_cnt = 0;
    chk("start_t1", core_start_o, 1);
    chk("busy_t1", busy_o, 1);
    chk("err_clr", wr_err_o, 0);
    tick();
    chk("start_arm", core_start_o, 0);
    tick();
    if (hold) core_done_i = 0;
    early = 0;
    for (int i = 0; i < dly - 2; i++) begin
      if (out_valid_o) early++;
      if (wait_wr && i == 5) begin
        wr_en_i = 1; wr_addr_i = 6'd5; wr_data_i = 32'hDEAD_BEEF;
      end
      tick();
      if (wait_wr && i == 5) begin
        wr_en_i = 0; m_err = 1;
      end
    end
    chk("no_early", early, 0);
    chk("wait_busy", busy_o, 1);
    core_done_i = 1; d = cyc;
    tick();
    core_done_i = 0;
    chk("valid_d1", out_valid_o, 1);
`ifdef SKINNY_CTRL_TRIGGER_EN
    chk("trig_span", trig_cnt, d - t_start);
`endif
    cycles = 0; stall = (rmode == 2) ? 5 : 0;
    for (int i = 0; i < 300 && op_hs < 8; i++) begin
      if (rmode == 0) out_ready_i = 1;
      else if (op_hs == 3 && stall > 0) begin out_ready_i = 0; stall--; end
      else out_ready_i = 1'($urandom_range(0, 1));
      cycles++;
      tick();
    end
    out_ready_i = 0;
    chk("hs_count", op_hs, 8);
    if (rmode == 0) chk("zero_bubble", cycles, 8);
    if (rmode == 2) chk("stall_done", stall, 0);
    chk("busy_after", busy_o, 0);
    chk("valid_after", out_valid_o, 0);
    chk("start_pulses", starts - s0, 1);
    chk("q_empty", exp_q.size(), 0);
  endtask

  task automatic abort_op(input bit in_read, input string tag);
    go_i = 1; tick(); go_i = 0; m_err = 0;
    tick(); tick(); tick();
    chk({tag, "_in_wait"}, busy_o, 1);
    if (in_read) begin
      core_done_i = 1; tick(); core_done_i = 0;
      out_ready_i = 0; tick(); tick();
      chk({tag, "_in_read"}, out_valid_o, 1);
    end
    do_reset(1, tag);
  endtask

  initial begin
    for (int a = 0; a < 62; a++) mem[a] = '0;
    do_reset(2, "reset");
    cmp_en = 1;

    // Load every operand word.
    for (int a = 0; a < 62; a++) wr(a, dat(a));
    chk("pin_tweak1", core_tweak1_o, 128'h00080000_00040000_00020000_00010000);
    chk("pin_rand_top", core_random_o[1215:1184], 32'hFFFF003D);
    chk("pin_model_w0", m_cword(0), 32'h01010101);
    chk("pin_model_w4", m_cword(4), 32'h10101010);
    chk("pin_model_w7", m_cword(7), 32'h80808080);

    run_op(200, 0, 0, 0, -1, '0);

    // Unmapped write sets the sticky error; a dropped write in WAIT too.
    wr(63, 32'hCAFE_F00D);
    tick(); tick();
    chk("err_63", wr_err_o, 1);
    run_op(40, 0, 0, 1, -1, '0);
    chk("err_sticky", wr_err_o, 1);
    chk("pin_w5_kept", core_input_o[191:160], 32'h0000_0020);

    // Done held through START/ARM; next go also clears the error.
    run_op(20, 1, 0, 0, -1, '0);

    // Random backpressure plus write coinciding with go.
    run_op(30, 0, 2, 0, 3, 32'h0000_0F00);
    chk("pin_co_write", core_input_o[127:96], 32'h0000_0F00);

    abort_op(0, "rst_wait");
    abort_op(1, "rst_read");
    tick();
    chk("final_idle", busy_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
